// File: rtl/div_issue_ctrl_if.sv
// Bundle of EX request/result and divider-core AXI-stream signals used by div_issue_ctrl.
// master = controller side, slave = EX pipeline plus the two divider cores.
interface div_issue_ctrl_if #(
    parameter int XLEN = 32
);
    logic              req_valid;
    logic [3:0]        req_op;
    logic [XLEN-1:0]   req_src1;
    logic [XLEN-1:0]   req_src2;
    logic              req_ready;
    logic              cancel;
    logic              res_valid;
    logic [XLEN-1:0]   res_data;
    logic              res_ack;
    logic              busy;

    logic [XLEN-1:0]   div_a_tdata;
    logic [XLEN-1:0]   div_b_tdata;

    logic              s_dividend_tvalid;
    logic              s_divisor_tvalid;
    logic              s_dividend_tready;
    logic              s_divisor_tready;
    logic              s_dout_tvalid;
    logic [2*XLEN-1:0] s_dout_tdata;

    logic              u_dividend_tvalid;
    logic              u_divisor_tvalid;
    logic              u_dividend_tready;
    logic              u_divisor_tready;
    logic              u_dout_tvalid;
    logic [2*XLEN-1:0] u_dout_tdata;

    modport master (
        input  req_valid, req_op, req_src1, req_src2, cancel, res_ack,
        input  s_dividend_tready, s_divisor_tready, s_dout_tvalid, s_dout_tdata,
        input  u_dividend_tready, u_divisor_tready, u_dout_tvalid, u_dout_tdata,
        output req_ready, res_valid, res_data, busy, div_a_tdata, div_b_tdata,
        output s_dividend_tvalid, s_divisor_tvalid, u_dividend_tvalid, u_divisor_tvalid
    );

    modport slave (
        output req_valid, req_op, req_src1, req_src2, cancel, res_ack,
        output s_dividend_tready, s_divisor_tready, s_dout_tvalid, s_dout_tdata,
        output u_dividend_tready, u_divisor_tready, u_dout_tvalid, u_dout_tdata,
        input  req_ready, res_valid, res_data, busy, div_a_tdata, div_b_tdata,
        input  s_dividend_tvalid, s_divisor_tvalid, u_dividend_tvalid, u_divisor_tvalid
    );
endinterface

// File: rtl/div_issue_ctrl.sv
// Issues one div/mod at a time to the signed/unsigned divider cores and holds the result for EX.
// IDLE: ready for a request | ISSUE: AXI operand handshakes | WAIT: await core result | DONE: result held | DRAIN: discard cancelled result
module div_issue_ctrl #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              resetn,
    div_issue_ctrl_if.master  bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    logic [2:0]      r_state;
    logic            r_signed;
    logic            r_quot;
    logic            r_cancel;
    logic            r_s_a_vld;
    logic            r_s_b_vld;
    logic            r_u_a_vld;
    logic            r_u_b_vld;
    logic [XLEN-1:0] r_div_a;
    logic [XLEN-1:0] r_div_b;
    logic [XLEN-1:0] r_res_data;
    logic            r_res_valid;

    logic            w_accept;
    logic            w_req_signed;
    logic            w_a_fire;
    logic            w_b_fire;
    logic            w_a_pend_nxt;
    logic            w_b_pend_nxt;
    logic            w_dout_vld;
    logic [2*XLEN-1:0] w_dout_data;
    logic [XLEN-1:0] w_dout_sel;

    assign w_accept     = (r_state == S_IDLE) & bus.req_valid & ~bus.cancel & $onehot(bus.req_op);
    assign w_req_signed = bus.req_op[3] | bus.req_op[2];

    assign w_a_fire     = (r_s_a_vld & bus.s_dividend_tready) | (r_u_a_vld & bus.u_dividend_tready);
    assign w_b_fire     = (r_s_b_vld & bus.s_divisor_tready)  | (r_u_b_vld & bus.u_divisor_tready);
    assign w_a_pend_nxt = (r_s_a_vld | r_u_a_vld) & ~w_a_fire;
    assign w_b_pend_nxt = (r_s_b_vld | r_u_b_vld) & ~w_b_fire;

    // Only the core that was actually issued to can complete the operation.
    assign w_dout_vld   = r_signed ? bus.s_dout_tvalid : bus.u_dout_tvalid;
    assign w_dout_data  = r_signed ? bus.s_dout_tdata  : bus.u_dout_tdata;
    assign w_dout_sel   = r_quot ? w_dout_data[2*XLEN-1:XLEN] : w_dout_data[XLEN-1:0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_signed    <= 1'b0;
            r_quot      <= 1'b0;
            r_cancel    <= 1'b0;
            r_s_a_vld   <= 1'b0;
            r_s_b_vld   <= 1'b0;
            r_u_a_vld   <= 1'b0;
            r_u_b_vld   <= 1'b0;
            r_div_a     <= '0;
            r_div_b     <= '0;
            r_res_data  <= '0;
            r_res_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_signed  <= w_req_signed;
                        r_quot    <= bus.req_op[3] | bus.req_op[1];
                        r_cancel  <= 1'b0;
                        r_div_a   <= bus.req_src1;
                        r_div_b   <= bus.req_src2;
                        r_s_a_vld <= w_req_signed;
                        r_s_b_vld <= w_req_signed;
                        r_u_a_vld <= ~w_req_signed;
                        r_u_b_vld <= ~w_req_signed;
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // Valids are never retracted; a cancel is remembered until both channels finish.
                    if (w_a_fire) begin
                        r_s_a_vld <= 1'b0;
                        r_u_a_vld <= 1'b0;
                    end
                    if (w_b_fire) begin
                        r_s_b_vld <= 1'b0;
                        r_u_b_vld <= 1'b0;
                    end
                    if (bus.cancel) begin
                        r_cancel <= 1'b1;
                    end
                    if (!w_a_pend_nxt && !w_b_pend_nxt) begin
                        r_state <= (r_cancel | bus.cancel) ? S_DRAIN : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.cancel) begin
                        r_state <= w_dout_vld ? S_IDLE : S_DRAIN;
                    end else if (w_dout_vld) begin
                        r_res_data  <= w_dout_sel;
                        r_res_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.cancel || bus.res_ack) begin
                        r_res_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (w_dout_vld) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready         = (r_state == S_IDLE);
    assign bus.busy              = (r_state != S_IDLE);
    assign bus.res_valid         = r_res_valid;
    assign bus.res_data          = r_res_data;
    assign bus.div_a_tdata       = r_div_a;
    assign bus.div_b_tdata       = r_div_b;
    assign bus.s_dividend_tvalid = r_s_a_vld;
    assign bus.s_divisor_tvalid  = r_s_b_vld;
    assign bus.u_dividend_tvalid = r_u_a_vld;
    assign bus.u_divisor_tvalid  = r_u_b_vld;
endmodule
